// File: rtl/capture_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : capture_seq_pkg
// Brief    : Shared types and constants for the capture sequencer: sequencer
//            state encoding, default widths and the frame counter width.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package capture_seq_pkg;

    localparam int DEF_NUM_CH    = 3;
    localparam int DEF_DATA_W    = 128;
    localparam int DEF_ADDR_W    = 29;
    localparam int DEF_SADDR_W   = 30;
    localparam int DEF_CNT_W     = 9;
    localparam int DEF_TIMEOUT_W = 24;

    localparam int FRAME_CNT_W   = 16;
    localparam int STATE_W       = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/capture_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : capture_sequencer_if
// Brief    : MIG write-port bundle between the capture sequencer (master) and
//            the memory controller (slave).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface capture_sequencer_if
    import capture_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              mem_wr_ack;
    logic              mem_wdata_rd_en;
    logic [DATA_W-1:0] mem_wdf_data;
    logic [CNT_W-1:0]  fifo_rd_data_count;

    modport master (
        output mem_wr_req,
        output mem_wr_addr,
        output mem_wdf_data,
        output fifo_rd_data_count,
        input  mem_wr_ack,
        input  mem_wdata_rd_en
    );

    modport slave (
        input  mem_wr_req,
        input  mem_wr_addr,
        input  mem_wdf_data,
        input  fifo_rd_data_count,
        output mem_wr_ack,
        output mem_wdata_rd_en
    );

endinterface

`default_nettype wire

// File: rtl/capture_seq_prienc.sv
//------------------------------------------------------------------------------
// Module   : capture_seq_prienc
// Brief    : Finds the lowest set request bit at or above a base index and
//            reports its index plus a found flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module capture_seq_prienc
    import capture_seq_pkg::*;
#(
    parameter int WIDTH = DEF_NUM_CH,
    parameter int IDX_W = 2
) (
    input  wire  [WIDTH-1:0] req_i,
    input  wire  [IDX_W-1:0] base_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the top down so the last hit written is the lowest qualifying bit.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i] && (i >= int'(base_i))) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/capture_sequencer.sv
//------------------------------------------------------------------------------
// Module   : capture_sequencer
// Brief    : N-channel capture sequencer and MIG write-path mux. One trigger
//            arms each enabled camera channel in ascending order, chaining
//            start addresses from each channel's saved end address.
// Options  : CAPTURE_SEQ_TIMEOUT_EN - adds timeout_limit input and a per-channel
//            WAIT watchdog that abandons a silent channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SADDR_W   = DEF_SADDR_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  wire                       mem_clk,
    input  wire                       mem_reset_n,
    input  wire                       trigger,
    input  wire  [SADDR_W-1:0]        start_addr,
    input  wire  [NUM_CH-1:0]         ch_enable,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      trigger_dropped,
    output logic [FRAME_CNT_W-1:0]    frame_count,
    output logic [NUM_CH-1:0]         ch_trigger,
    output logic [SADDR_W-1:0]        ch_start_addr,
    input  wire  [NUM_CH*SADDR_W-1:0] ch_saved_addr,
    input  wire  [NUM_CH-1:0]         ch_frame_written,
    input  wire  [NUM_CH-1:0]         ch_wr_req,
    input  wire  [NUM_CH*ADDR_W-1:0]  ch_wr_addr,
    input  wire  [NUM_CH*DATA_W-1:0]  ch_wdf_data,
    input  wire  [NUM_CH*CNT_W-1:0]   ch_fifo_count,
    output logic [NUM_CH-1:0]         ch_wr_ack,
    output logic [NUM_CH-1:0]         ch_rd_en,
    capture_sequencer_if.master       mig,
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    input  wire  [TIMEOUT_W-1:0]      timeout_limit,
`endif
    output logic                      timeout_err
);

    localparam int IDX_W = idx_w(NUM_CH);

    if ((NUM_CH < 1) || (NUM_CH > 8) || (TIMEOUT_W < 1)) begin : g_param_check
        $error("capture_sequencer: NUM_CH must be 1..8 and TIMEOUT_W >= 1");
    end

    state_e                   state_q, state_d;
    logic [NUM_CH-1:0]        en_q;
    logic [SADDR_W-1:0]       addr_q;
    logic [SADDR_W-1:0]       start_q;
    logic [IDX_W-1:0]         act_q;
    logic [IDX_W-1:0]         base_q;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;

    logic [IDX_W-1:0]         w_sel_idx;
    logic                     w_sel_found;
    logic                     w_written;
    logic                     w_timeout;

    logic [SADDR_W-1:0]       w_saved [NUM_CH];
    logic [ADDR_W-1:0]        w_addr  [NUM_CH];
    logic [DATA_W-1:0]        w_data  [NUM_CH];
    logic [CNT_W-1:0]         w_cnt   [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_saved[g] = ch_saved_addr[g*SADDR_W +: SADDR_W];
        assign w_addr[g]  = ch_wr_addr[g*ADDR_W +: ADDR_W];
        assign w_data[g]  = ch_wdf_data[g*DATA_W +: DATA_W];
        assign w_cnt[g]   = ch_fifo_count[g*CNT_W +: CNT_W];
    end

    capture_seq_prienc #(
        .WIDTH (NUM_CH),
        .IDX_W (IDX_W)
    ) u_prienc (
        .req_i   (en_q),
        .base_i  (base_q),
        .idx_o   (w_sel_idx),
        .found_o (w_sel_found)
    );

    // Only the active channel's completion counts, and only while waiting on it.
    assign w_written = (state_q == ST_WAIT) && ch_frame_written[act_q];

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q;
    logic                 to_err_q;

    // The count includes the current WAIT cycle, so the limit-th cycle expires.
    assign w_timeout = (state_q == ST_WAIT) && (timeout_limit != '0) &&
                       (TIMEOUT_W'(to_cnt_q + 1'b1) == timeout_limit);

    // Watchdog counter restarts for each channel; error is sticky until reset.
    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state_q == ST_ARM) begin
                to_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (w_timeout && !w_written) begin
                to_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = to_err_q;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (trigger) state_d = ST_SELECT;
            ST_SELECT: state_d = w_sel_found ? ST_ARM : ST_DONE;
            ST_ARM:    state_d = ST_WAIT;
            ST_WAIT:   if (w_written || w_timeout) state_d = ST_SELECT;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequence datapath: enable mask, address chain, active/search index, frame count.
    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            en_q        <= '0;
            addr_q      <= '0;
            start_q     <= '0;
            act_q       <= '0;
            base_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        en_q   <= ch_enable;
                        addr_q <= start_addr;
                    end
                end
                ST_SELECT: begin
                    if (w_sel_found) begin
                        act_q   <= w_sel_idx;
                        base_q  <= w_sel_idx;
                        start_q <= addr_q;
                    end
                end
                ST_WAIT: begin
                    if (w_written) begin
                        addr_q      <= w_saved[act_q];
                        en_q[act_q] <= 1'b0;
                    end else if (w_timeout) begin
                        en_q[act_q] <= 1'b0;
                    end
                end
                ST_DONE: begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                    base_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs from the state, plus the dropped-trigger indication.
    always_comb begin
        busy            = (state_q != ST_IDLE);
        frame_done      = (state_q == ST_DONE);
        trigger_dropped = trigger && (state_q != ST_IDLE);
        ch_trigger      = '0;
        if (state_q == ST_ARM) begin
            ch_trigger[act_q] = 1'b1;
        end
    end

    assign frame_count   = frame_cnt_q;
    assign ch_start_addr = start_q;

    // Write-path mux follows the registered active index in every state.
    assign mig.mem_wr_req         = ch_wr_req[act_q];
    assign mig.mem_wr_addr        = w_addr[act_q];
    assign mig.mem_wdf_data       = w_data[act_q];
    assign mig.fifo_rd_data_count = w_cnt[act_q];

    // Return-path demux: ack and read-enable reach the active channel only.
    always_comb begin
        ch_wr_ack = '0;
        ch_rd_en  = '0;
        ch_wr_ack[act_q] = mig.mem_wr_ack;
        ch_rd_en[act_q]  = mig.mem_wdata_rd_en;
    end

endmodule

`default_nettype wire
